// File: rtl/haar_window_evaluator.sv
// rtl/haar_window_evaluator.sv - two-rectangle Haar feature evaluator on an integral-image window
module haar_window_evaluator #(
    parameter int        WindowSize = 4,
    parameter int signed ThreshV    = 4,
    parameter int signed ThreshH    = 4,
    parameter int        MinCount   = 4,
    parameter int        IndexWidth = 16,
    localparam int       WDI        = $clog2(WindowSize * WindowSize + 1),
    localparam int       WF         = WDI + 1
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               BufferReady,
    input  logic [WDI*WindowSize*WindowSize-1:0] IntegralPacked,
    output logic                               Busy,
    output logic                               ResultValid,
    output logic                               Match,
    output logic [WDI-1:0]                     WindowCount,
    output logic [WF-1:0]                      FeatureV,
    output logic [WF-1:0]                      FeatureH,
    output logic [IndexWidth-1:0]              WindowIndex,
    output logic                               Dropped
);

    localparam int N    = WindowSize;
    localparam int H    = WindowSize / 2;
    localparam int PW   = WDI * N * N;

    // Bit offsets of the three integral corners the features need.
    localparam int POS_S = WDI * ((N - 1) * N + (N - 1));
    localparam int POS_L = WDI * ((N - 1) * N + (H - 1));
    localparam int POS_T = WDI * ((H - 1) * N + (N - 1));

    localparam logic signed [WF-1:0] TH_V  = WF'(ThreshV);
    localparam logic signed [WF-1:0] TH_H  = WF'(ThreshH);
    localparam logic [WDI-1:0]       MIN_C = WDI'(MinCount);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_DIFF = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t state, state_next;

    logic                 rdy_prev;
    logic                 trigger;
    logic [PW-1:0]        win;
    logic [WDI-1:0]       s_reg;
    logic [WDI-1:0]       l_reg;
    logic [WDI-1:0]       t_reg;
    logic signed [WF-1:0] fv_reg;
    logic signed [WF-1:0] fh_reg;

    // rdy_prev resets high so a level already asserted through reset is not seen as a new window.
    assign trigger = BufferReady & ~rdy_prev;

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed four-step walk once a window is captured.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (trigger) state_next = ST_SUM;
            ST_SUM:  state_next = ST_DIFF;
            ST_DIFF: state_next = ST_OUT;
            ST_OUT:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture, corner extraction, feature differences and the registered result.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdy_prev    <= 1'b1;
            win         <= '0;
            s_reg       <= '0;
            l_reg       <= '0;
            t_reg       <= '0;
            fv_reg      <= '0;
            fh_reg      <= '0;
            Busy        <= 1'b0;
            ResultValid <= 1'b0;
            Match       <= 1'b0;
            WindowCount <= '0;
            FeatureV    <= '0;
            FeatureH    <= '0;
            WindowIndex <= '0;
            Dropped     <= 1'b0;
        end else begin
            rdy_prev    <= BufferReady;
            Dropped     <= trigger && (state != ST_IDLE);
            ResultValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Busy stays up through the result cycle and drops here unless a new window starts.
                    Busy <= trigger;
                    if (trigger) begin
                        win <= IntegralPacked;
                    end
                end
                ST_SUM: begin
                    s_reg <= win[POS_S +: WDI];
                    l_reg <= win[POS_L +: WDI];
                    t_reg <= win[POS_T +: WDI];
                end
                ST_DIFF: begin
                    // 2L may wrap in WF bits; the modular difference still lands on the exact value.
                    fv_reg <= $signed({l_reg, 1'b0}) - $signed({1'b0, s_reg});
                    fh_reg <= $signed({t_reg, 1'b0}) - $signed({1'b0, s_reg});
                end
                ST_OUT: begin
                    WindowCount <= s_reg;
                    FeatureV    <= fv_reg;
                    FeatureH    <= fh_reg;
                    Match       <= (s_reg >= MIN_C) && ((fv_reg >= TH_V) || (fh_reg >= TH_H));
                    ResultValid <= 1'b1;
                    WindowIndex <= WindowIndex + IndexWidth'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_haar_window_evaluator.sv
// tb/tb_haar_window_evaluator.sv - scoreboard bench for haar_window_evaluator
module tb_haar_window_evaluator;

    localparam int N   = 4;
    localparam int WDI = 5;
    localparam int WF  = 6;
    localparam int IW  = 16;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              BufferReady;
    logic [WDI*N*N-1:0] IntegralPacked;
    logic              Busy;
    logic              ResultValid;
    logic              Match;
    logic [WDI-1:0]    WindowCount;
    logic [WF-1:0]     FeatureV;
    logic [WF-1:0]     FeatureH;
    logic [IW-1:0]     WindowIndex;
    logic              Dropped;

    haar_window_evaluator #(
        .WindowSize(4), .ThreshV(4), .ThreshH(4), .MinCount(4), .IndexWidth(16)
    ) dut (
        .Clock(Clock), .Reset(Reset), .BufferReady(BufferReady),
        .IntegralPacked(IntegralPacked), .Busy(Busy), .ResultValid(ResultValid),
        .Match(Match), .WindowCount(WindowCount), .FeatureV(FeatureV),
        .FeatureH(FeatureH), .WindowIndex(WindowIndex), .Dropped(Dropped)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int cnt;
        int fv;
        int fh;
        int m;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_idx = 0;

    // Hand-computed results for each window kind: count, FV, FH, Match.
    int exp_cnt [7] = '{16,  8,  8, 0, 8, 4, 3};
    int exp_fv  [7] = '{ 0,  8, -8, 0, 0, 4, 3};
    int exp_fh  [7] = '{ 0,  0,  0, 0, 8, 0, 1};
    int exp_m   [7] = '{ 0,  1,  0, 0, 1, 1, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Integral image of a small set of binary test windows.
    function automatic logic [WDI*N*N-1:0] mk(input int kind);
        logic [WDI*N*N-1:0] v;
        int x;
        v = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (kind)
                    0: x = (r + 1) * (c + 1);
                    1: x = (r + 1) * ((c + 1 < 2) ? c + 1 : 2);
                    2: x = (r + 1) * ((c - 1 > 0) ? c - 1 : 0);
                    4: x = ((r + 1 < 2) ? r + 1 : 2) * (c + 1);
                    5: x = r + 1;
                    6: x = (r + 1 < 3) ? r + 1 : 3;
                    default: x = 0;
                endcase
                v[WDI*(r*N+c) +: WDI] = x[WDI-1:0];
            end
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input int kind);
        exp_t e;
        exp_idx++;
        e.cnt = exp_cnt[kind];
        e.fv  = exp_fv[kind];
        e.fh  = exp_fh[kind];
        e.m   = exp_m[kind];
        e.idx = exp_idx;
        sb.push_back(e);
    endtask

    // One isolated window: rising edge, capture, result three edges later.
    task automatic run_window(input int kind);
        BufferReady = 1'b0;
        IntegralPacked = mk(kind);
        tick();
        BufferReady = 1'b1;
        push(kind);
        tick();                         // E0 capture
        IntegralPacked = '1;            // must not disturb the captured window
        chk("busy_after_capture", int'(Busy), 1);
        tick();
        tick();                         // E2
        chk("no_early_result", int'(ResultValid), 0);
        tick();                         // E3
        chk("result_latency", int'(ResultValid), 1);
        chk("busy_in_result_cycle", int'(Busy), 1);
        BufferReady = 1'b0;
    endtask

    // Monitor: every result strobe is checked against the oldest expected entry.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && ResultValid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("window_count", int'(WindowCount), e.cnt);
                chk("feature_v", int'($signed(FeatureV)), e.fv);
                chk("feature_h", int'($signed(FeatureH)), e.fh);
                chk("match", int'(Match), e.m);
                chk("window_index", int'(WindowIndex), e.idx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        BufferReady = 1'b1;
        IntegralPacked = mk(0);
        repeat (3) tick();
        chk("reset_busy", int'(Busy), 0);
        chk("reset_count", int'(WindowCount), 0);
        Reset = 1'b0;
        repeat (3) tick();
        chk("held_ready_busy", int'(Busy), 0);
        chk("held_ready_valid", int'(ResultValid), 0);
        chk("held_ready_dropped", int'(Dropped), 0);
        chk("held_ready_index", int'(WindowIndex), 0);
        chk("held_ready_match", int'(Match), 0);

        for (int k = 0; k < 7; k++) begin
            run_window(k);
        end

        // Second rising edge during DIFF is dropped; result belongs to the first window.
        tick();
        IntegralPacked = mk(1);
        BufferReady = 1'b1;
        push(1);
        tick();                         // E0
        BufferReady = 1'b0;
        IntegralPacked = mk(0);
        tick();                         // E1
        BufferReady = 1'b1;
        tick();                         // E2 trigger dropped
        chk("dropped_pulse", int'(Dropped), 1);
        tick();                         // E3
        chk("dropped_one_cycle", int'(Dropped), 0);
        chk("result_after_drop", int'(ResultValid), 1);
        BufferReady = 1'b0;

        // Trigger on the OUT edge is dropped, with Dropped and ResultValid together.
        tick();
        IntegralPacked = mk(4);
        BufferReady = 1'b1;
        push(4);
        tick();                         // E0
        BufferReady = 1'b0;
        tick();
        tick();                         // E2
        BufferReady = 1'b1;
        IntegralPacked = mk(0);
        tick();                         // E3 trigger while in OUT
        chk("drop_at_out", int'(Dropped), 1);
        chk("valid_with_drop", int'(ResultValid), 1);
        BufferReady = 1'b0;

        // Back-to-back: trigger one edge after OUT is accepted.
        tick();
        IntegralPacked = mk(1);
        BufferReady = 1'b1;
        push(1);
        tick();                         // E0
        BufferReady = 1'b0;
        tick();
        tick();
        tick();                         // E3
        BufferReady = 1'b1;
        IntegralPacked = mk(6);
        push(6);
        tick();                         // E4 accepted
        chk("b2b_no_drop", int'(Dropped), 0);
        chk("b2b_busy", int'(Busy), 1);
        tick();
        tick();
        tick();                         // E7
        chk("b2b_result", int'(ResultValid), 1);
        BufferReady = 1'b0;

        // Reset while in DIFF aborts the evaluation and clears everything.
        tick();
        IntegralPacked = mk(1);
        BufferReady = 1'b1;
        tick();                         // E0
        BufferReady = 1'b0;
        tick();                         // E1, now in DIFF
        Reset = 1'b1;
        tick();                         // E2
        chk("rst_mid_busy", int'(Busy), 0);
        chk("rst_mid_count", int'(WindowCount), 0);
        chk("rst_mid_fv", int'(FeatureV), 0);
        chk("rst_mid_match", int'(Match), 0);
        chk("rst_mid_index", int'(WindowIndex), 0);
        chk("rst_mid_valid", int'(ResultValid), 0);
        tick();
        Reset = 1'b0;
        exp_idx = 0;
        tick();
        chk("rst_no_result", int'(ResultValid), 0);
        run_window(2);

        repeat (4) tick();
        chk("all_results_seen", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
